// File: rtl/axi_burst_addr_gen_if.sv
// ----------------------------------------------------------------------------
// axi_burst_addr_gen_if
// Command and beat-descriptor bundle for the AXI burst address generator.
//   cmd_*  : one AR/AW-style command per cmd_valid/cmd_ready handshake
//   beat_* : one beat descriptor per beat_valid/beat_ready handshake
// Modports:
//   master : the side that issues commands and consumes beats (L2 FSM / sequencer)
//   slave  : the generator itself
// ----------------------------------------------------------------------------
interface axi_burst_addr_gen_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic [2:0]            cmd_size;
    logic [1:0]            cmd_burst;

    logic                  beat_valid;
    logic                  beat_ready;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic [STRB_WIDTH-1:0] beat_strb;
    logic [LEN_WIDTH-1:0]  beat_idx;
    logic                  beat_last;
    logic                  beat_err;

    modport master (
        output cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
        input  cmd_ready, beat_valid, beat_addr, beat_strb, beat_idx, beat_last, beat_err
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
        output cmd_ready, beat_valid, beat_addr, beat_strb, beat_idx, beat_last, beat_err
    );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// ----------------------------------------------------------------------------
// axi_burst_addr_gen
// AXI4 burst address generator. Latches one command (addr, len, size, burst)
// and then emits len+1 beat descriptors (address, byte strobe, index, last,
// error) under downstream backpressure. Supports FIXED, INCR and WRAP bursts,
// narrow and unaligned transfers, and flags illegal commands on beat_err while
// still emitting every beat so the consumer can drain the transaction.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : axi_burst_addr_gen_if.slave (cmd_* in, beat_* out)
// ----------------------------------------------------------------------------
module axi_burst_addr_gen #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axi_burst_addr_gen_if.slave   bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int SIZE_MAX   = $clog2(STRB_WIDTH);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic {IDLE, BURST} state_t;

    state_t state, next_state;

    // Latched command (already sanitised) and registered beat outputs
    logic [LEN_WIDTH-1:0]  len_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic [ADDR_WIDTH-1:0] wrap_lo_q;
    logic [ADDR_WIDTH-1:0] wrap_hi_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [STRB_WIDTH-1:0] strb_q;
    logic [LEN_WIDTH-1:0]  idx_q;
    logic                  last_q;
    logic                  err_q;

    logic beat_valid_int;
    logic cmd_ready_int;
    logic cmd_fire;
    logic beat_fire;

    // Command decode
    logic [2:0]            cmd_size_eff;
    logic [1:0]            cmd_burst_eff;
    logic [ADDR_WIDTH-1:0] cmd_aligned;
    logic [ADDR_WIDTH-1:0] cmd_ws;
    logic [ADDR_WIDTH-1:0] cmd_wrap_lo;
    logic [ADDR_WIDTH-1:0] cmd_incr_last;
    logic [ADDR_WIDTH-1:0] cmd_start;
    logic                  wrap_len_ok;
    logic                  cmd_err;

    logic [ADDR_WIDTH-1:0] next_addr;

    // Clears the low 'sz' address bits
    function automatic logic [ADDR_WIDTH-1:0] align_mask(input logic [2:0] sz);
        align_mask = ~((ADDR_WIDTH'(1) << sz) - ADDR_WIDTH'(1));
    endfunction

    // Active lanes run from the start byte up to the end of the aligned beat
    function automatic logic [STRB_WIDTH-1:0] calc_strb(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [2:0]            sz);
        logic [ADDR_WIDTH-1:0] al;
        int lo;
        int hi;
        al = a & align_mask(sz);
        lo = int'(a & ADDR_WIDTH'(STRB_WIDTH - 1));
        hi = int'(al & ADDR_WIDTH'(STRB_WIDTH - 1)) + (1 << int'(sz)) - 1;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            calc_strb[i] = (i >= lo) && (i <= hi);
        end
    endfunction

    // Sanitise the incoming command and work out whether it is legal.
    // An oversize beat is clamped to the bus width, a reserved burst type runs
    // as FIXED, and a WRAP with an illegal length runs as INCR because it has
    // no power-of-two wrap window to stay inside.
    always_comb begin
        cmd_size_eff  = (int'(bus.cmd_size) > SIZE_MAX) ? 3'(SIZE_MAX) : bus.cmd_size;
        cmd_aligned   = bus.cmd_addr & align_mask(cmd_size_eff);
        cmd_ws        = (ADDR_WIDTH'(bus.cmd_len) + ADDR_WIDTH'(1)) << cmd_size_eff;
        cmd_wrap_lo   = cmd_aligned & ~(cmd_ws - ADDR_WIDTH'(1));
        cmd_incr_last = cmd_aligned + (ADDR_WIDTH'(bus.cmd_len) << cmd_size_eff);
        wrap_len_ok   = (bus.cmd_len == LEN_WIDTH'(1))  || (bus.cmd_len == LEN_WIDTH'(3)) ||
                        (bus.cmd_len == LEN_WIDTH'(7))  || (bus.cmd_len == LEN_WIDTH'(15));

        cmd_err = (int'(bus.cmd_size) > SIZE_MAX)
               || (bus.cmd_burst == BURST_RSVD)
               || ((bus.cmd_burst == BURST_WRAP) && !wrap_len_ok)
               || ((bus.cmd_burst == BURST_WRAP) && (cmd_aligned != bus.cmd_addr))
               || ((bus.cmd_burst == BURST_INCR) &&
                   (((cmd_incr_last ^ bus.cmd_addr) >> 12) != '0))
               || ((bus.cmd_burst == BURST_FIXED) && (bus.cmd_len > LEN_WIDTH'(15)));

        cmd_burst_eff = bus.cmd_burst;
        if (bus.cmd_burst == BURST_RSVD) begin
            cmd_burst_eff = BURST_FIXED;
        end else if ((bus.cmd_burst == BURST_WRAP) && !wrap_len_ok) begin
            cmd_burst_eff = BURST_INCR;
        end

        cmd_start = (cmd_burst_eff == BURST_WRAP) ? cmd_aligned : bus.cmd_addr;
    end

    // Address of the beat after the current one
    always_comb begin
        next_addr = addr_q;
        case (burst_q)
            BURST_INCR: next_addr = (addr_q & align_mask(size_q)) + (ADDR_WIDTH'(1) << size_q);
            BURST_WRAP: begin
                next_addr = addr_q + (ADDR_WIDTH'(1) << size_q);
                if (next_addr == wrap_hi_q) begin
                    next_addr = wrap_lo_q;
                end
            end
            default:    next_addr = addr_q;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a last-beat handshake either ends the burst or, with a
    // simultaneous command, rolls straight into the next one
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cmd_fire) next_state = BURST;
            BURST:   if (beat_fire && last_q && !cmd_fire) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs; cmd_ready is held low while reset is asserted
    always_comb begin
        beat_valid_int = (state == BURST);
        cmd_ready_int  = rst_n && ((state == IDLE) ||
                                   (beat_valid_int && bus.beat_ready && last_q));
    end

    assign cmd_fire  = bus.cmd_valid && cmd_ready_int;
    assign beat_fire = beat_valid_int && bus.beat_ready;

    // Beat datapath: load on command acceptance, advance on beat handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= BURST_FIXED;
            wrap_lo_q <= '0;
            wrap_hi_q <= '0;
            addr_q    <= '0;
            strb_q    <= '0;
            idx_q     <= '0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
        end else if (cmd_fire) begin
            len_q     <= bus.cmd_len;
            size_q    <= cmd_size_eff;
            burst_q   <= cmd_burst_eff;
            wrap_lo_q <= cmd_wrap_lo;
            wrap_hi_q <= cmd_wrap_lo + cmd_ws;
            addr_q    <= cmd_start;
            strb_q    <= calc_strb(cmd_start, cmd_size_eff);
            idx_q     <= '0;
            last_q    <= (bus.cmd_len == '0);
            err_q     <= cmd_err;
        end else if (beat_fire) begin
            if (last_q) begin
                last_q <= 1'b0;
            end else begin
                addr_q <= next_addr;
                strb_q <= calc_strb(next_addr, size_q);
                idx_q  <= idx_q + LEN_WIDTH'(1);
                last_q <= ((idx_q + LEN_WIDTH'(1)) == len_q);
            end
        end
    end

    assign bus.cmd_ready  = cmd_ready_int;
    assign bus.beat_valid = beat_valid_int;
    assign bus.beat_addr  = addr_q;
    assign bus.beat_strb  = strb_q;
    assign bus.beat_idx   = idx_q;
    assign bus.beat_last  = last_q;
    assign bus.beat_err   = err_q;

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// ----------------------------------------------------------------------------
// tb_axi_burst_addr_gen
// Directed self-checking bench for axi_burst_addr_gen (32-bit address, 32-bit
// data, 8-bit len). Inputs change 1 time unit after the rising edge; outputs
// are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_axi_burst_addr_gen;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 8;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;
    localparam logic [1:0] RSVD  = 2'b11;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   check_cnt;

    axi_burst_addr_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    axi_burst_addr_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a command and hold it until accepted; returns 1 time unit after
    // the accepting edge, when beat 0 is on the outputs
    task automatic send_cmd(input logic [31:0] a, input logic [7:0] l,
                            input logic [2:0] s, input logic [1:0] b);
        int budget;
        budget        = 0;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        bus.cmd_size  = s;
        bus.cmd_burst = b;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        while (!bus.cmd_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.cmd_ready) begin
            check_cnt++;
            $display("[TB] FAIL cmd_accept_timeout: cmd_ready=%b required 1", bus.cmd_ready);
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [47:0] got;
        rst_n          = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_addr   = '0;
        bus.cmd_len    = '0;
        bus.cmd_size   = '0;
        bus.cmd_burst  = '0;
        bus.beat_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        got = {bus.cmd_ready, bus.beat_valid, bus.beat_addr, bus.beat_strb,
               bus.beat_idx, bus.beat_last, bus.beat_err};
        check_cnt++;
        if (got !== 48'h0) $display("[TB] FAIL reset_state: got %h required %h", got, 48'h0);
        else pass_cnt++;
        rst_n = 1'b1;
        #1;
        check_cnt++;
        if (bus.cmd_ready !== 1'b1) $display("[TB] FAIL reset_release_ready: got %b required 1", bus.cmd_ready);
        else pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_incr();
        logic [31:0] ea [4];
        logic [3:0]  es [4];
        logic [46:0] got, exp;
        ea = '{32'h1002, 32'h1004, 32'h1008, 32'h100C};
        es = '{4'b1100, 4'b1111, 4'b1111, 4'b1111};
        send_cmd(32'h1002, 8'd3, 3'd2, INCR);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            got = {bus.beat_valid, bus.beat_addr, bus.beat_strb, bus.beat_idx, bus.beat_last, bus.beat_err};
            exp = {1'b1, ea[i], es[i], 8'(i), (i == 3), 1'b0};
            check_cnt++;
            if (got !== exp) $display("[TB] FAIL incr_beat%0d: got %h required %h", i, got, exp);
            else pass_cnt++;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check_cnt++;
        if (bus.beat_valid !== 1'b0) $display("[TB] FAIL incr_idle_after: beat_valid=%b required 0", bus.beat_valid);
        else pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap();
        logic [31:0] ea [4];
        logic [46:0] got, exp;
        logic [31:0] start [2];
        ea    = '{32'h38, 32'h3C, 32'h30, 32'h34};
        start = '{32'h38, 32'h3A};
        for (int t = 0; t < 2; t++) begin
            send_cmd(start[t], 8'd3, 3'd2, WRAP);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                got = {bus.beat_valid, bus.beat_addr, bus.beat_strb, bus.beat_idx, bus.beat_last, bus.beat_err};
                exp = {1'b1, ea[i], 4'b1111, 8'(i), (i == 3), (t == 1)};
                check_cnt++;
                if (got !== exp) $display("[TB] FAIL wrap%0d_beat%0d: got %h required %h", t, i, got, exp);
                else pass_cnt++;
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_fixed();
        logic [46:0] got, exp;
        send_cmd(32'h21, 8'd2, 3'd0, FIXED);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got = {bus.beat_valid, bus.beat_addr, bus.beat_strb, bus.beat_idx, bus.beat_last, bus.beat_err};
            exp = {1'b1, 32'h21, 4'b0010, 8'(i), (i == 2), 1'b0};
            check_cnt++;
            if (got !== exp) $display("[TB] FAIL fixed_beat%0d: got %h required %h", i, got, exp);
            else pass_cnt++;
            @(posedge clk);
            #1;
        end
        send_cmd(32'h21, 8'd1, 3'd0, RSVD);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            got = {bus.beat_valid, bus.beat_addr, bus.beat_strb, bus.beat_idx, bus.beat_last, bus.beat_err};
            exp = {1'b1, 32'h21, 4'b0010, 8'(i), (i == 1), 1'b1};
            check_cnt++;
            if (got !== exp) $display("[TB] FAIL rsvd_beat%0d: got %h required %h", i, got, exp);
            else pass_cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_4k_cross();
        logic [31:0] ea [4];
        logic [46:0] got, exp;
        ea = '{32'hFF8, 32'hFFC, 32'h1000, 32'h1004};
        send_cmd(32'hFF8, 8'd3, 3'd2, INCR);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            got = {bus.beat_valid, bus.beat_addr, bus.beat_strb, bus.beat_idx, bus.beat_last, bus.beat_err};
            exp = {1'b1, ea[i], 4'b1111, 8'(i), (i == 3), 1'b1};
            check_cnt++;
            if (got !== exp) $display("[TB] FAIL cross4k_beat%0d: got %h required %h", i, got, exp);
            else pass_cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [46:0] got, exp;
        int k;
        int cycles;
        k      = 0;
        cycles = 0;
        send_cmd(32'h200, 8'd7, 3'd2, INCR);
        while (k < 8 && cycles < 200) begin
            if (k == 7) begin
                bus.beat_ready = 1'b1;
                bus.cmd_addr   = 32'h400;
                bus.cmd_len    = 8'd1;
                bus.cmd_size   = 3'd2;
                bus.cmd_burst  = INCR;
                bus.cmd_valid  = 1'b1;
            end else begin
                bus.beat_ready = (cycles == 0) ? 1'b0 : ($urandom_range(0, 1) == 1);
            end
            @(negedge clk);
            got = {bus.beat_valid, bus.beat_addr, bus.beat_strb, bus.beat_idx, bus.beat_last, bus.beat_err};
            exp = {1'b1, 32'h200 + 32'(4 * k), 4'b1111, 8'(k), (k == 7), 1'b0};
            check_cnt++;
            if (got !== exp) $display("[TB] FAIL bp_beat%0d: got %h required %h", k, got, exp);
            else pass_cnt++;
            if (k == 7) begin
                check_cnt++;
                if (bus.cmd_ready !== 1'b1) $display("[TB] FAIL b2b_ready_on_last: got %b required 1", bus.cmd_ready);
                else pass_cnt++;
            end
            @(posedge clk);
            if (bus.beat_ready) k++;
            #1;
            cycles++;
        end
        bus.cmd_valid  = 1'b0;
        bus.beat_ready = 1'b1;
        check_cnt++;
        if (k !== 8) $display("[TB] FAIL bp_handshakes: got %0d required 8", k);
        else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            got = {bus.beat_valid, bus.beat_addr, bus.beat_strb, bus.beat_idx, bus.beat_last, bus.beat_err};
            exp = {1'b1, 32'h400 + 32'(4 * i), 4'b1111, 8'(i), (i == 1), 1'b0};
            check_cnt++;
            if (got !== exp) $display("[TB] FAIL b2b_beat%0d: got %h required %h", i, got, exp);
            else pass_cnt++;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check_cnt++;
        if (bus.beat_valid !== 1'b0) $display("[TB] FAIL b2b_idle_after: beat_valid=%b required 0", bus.beat_valid);
        else pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midburst();
        logic [46:0] got, exp;
        logic [42:0] rgot;
        send_cmd(32'h100, 8'd15, 3'd2, INCR);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got = {bus.beat_valid, bus.beat_addr, bus.beat_strb, bus.beat_idx, bus.beat_last, bus.beat_err};
            exp = {1'b1, 32'h100 + 32'(4 * i), 4'b1111, 8'(i), 1'b0, 1'b0};
            check_cnt++;
            if (got !== exp) $display("[TB] FAIL mid_beat%0d: got %h required %h", i, got, exp);
            else pass_cnt++;
            if (i < 2) begin
                @(posedge clk);
                #1;
            end
        end
        rst_n = 1'b0;
        #1;
        rgot = {bus.cmd_ready, bus.beat_valid, bus.beat_addr, bus.beat_idx, bus.beat_last};
        check_cnt++;
        if (rgot !== 43'h0) $display("[TB] FAIL mid_reset_abort: got %h required %h", rgot, 43'h0);
        else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_cnt++;
        if ({bus.cmd_ready, bus.beat_valid} !== 2'b10)
            $display("[TB] FAIL mid_release: got ready/valid %b required 10", {bus.cmd_ready, bus.beat_valid});
        else pass_cnt++;
        @(posedge clk);
        #1;
        send_cmd(32'h44, 8'd0, 3'd2, INCR);
        @(negedge clk);
        got = {bus.beat_valid, bus.beat_addr, bus.beat_strb, bus.beat_idx, bus.beat_last, bus.beat_err};
        exp = {1'b1, 32'h44, 4'b1111, 8'd0, 1'b1, 1'b0};
        check_cnt++;
        if (got !== exp) $display("[TB] FAIL len0_beat: got %h required %h", got, exp);
        else pass_cnt++;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_cnt++;
        if (bus.beat_valid !== 1'b0) $display("[TB] FAIL len0_idle_after: beat_valid=%b required 0", bus.beat_valid);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        check_cnt = 0;
        test_reset();
        test_incr();
        test_wrap();
        test_fixed();
        test_4k_cross();
        test_back_to_back();
        test_reset_midburst();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
